// File: rtl/uart_chan_param_if.sv
// CPU-side data register bus of one UART channel: select, direction,
// write data toward the channel and RX head character back to the CPU.
interface uart_chan_param_if;
    logic       i_Cs;
    logic       i_Rw;
    logic [7:0] i_Data;
    logic [7:0] o_Data;

    modport master (output i_Cs, output i_Rw, output i_Data, input o_Data);
    modport slave  (input i_Cs, input i_Rw, input i_Data, output o_Data);
endinterface

// File: rtl/uart_chan_param.sv
// One DUART serial channel: TX holding + shift register, oversampled receiver,
// RX FIFO with per-character PE/FE/RB flags, and the four channel loop modes.
module uart_chan_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int RX_DEPTH     = 3
) (
    input  logic             i_Clock,
    input  logic             i_Rst_L,
    uart_chan_param_if.slave bus,
    input  logic             i_RX,
    output logic             o_TX,
    input  logic             i_TxEN,
    input  logic             i_RxEN,
    input  logic             i_TxReset,
    input  logic             i_RxReset,
    input  logic             i_ErrReset,
    input  logic [1:0]       i_Parity,
    input  logic [1:0]       i_Mode,
    output logic             o_TxRDY,
    output logic             o_TxEMT,
    output logic             o_RxRDY,
    output logic             o_FFULL,
    output logic             o_OVER,
    output logic             o_PE,
    output logic             o_FE,
    output logic             o_RB
);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int PTR_W  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int FCNT_W = $clog2(RX_DEPTH + 1);
    localparam int EW     = DATA_BITS + 3;

    localparam logic [CNT_W-1:0]  LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_CLK = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(RX_DEPTH - 1);
    localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(RX_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic w_mode_echo, w_mode_local, w_mode_remote, w_par_en, w_par_odd;
    assign w_mode_echo   = (i_Mode == 2'b01);
    assign w_mode_local  = (i_Mode == 2'b10);
    assign w_mode_remote = (i_Mode == 2'b11);
    assign w_par_en      = (i_Parity == 2'b01) || (i_Parity == 2'b10);
    assign w_par_odd     = (i_Parity == 2'b10);

    // ------------------------------------------------------------------ TX
    state_t               r_tx_state, w_tx_state_next;
    logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_next;
    logic [BIT_W-1:0]     r_tx_bit, w_tx_bit_next;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_next;
    logic                 r_tx_par, w_tx_par_next;
    logic                 r_hold_full, w_hold_full_next;
    logic [DATA_BITS-1:0] r_hold_data, w_hold_data_next;
    logic                 w_tx_load, w_wr, w_echo_load, w_tx_line;

    // RX-side signals referenced by the TX path (auto-echo, local loop)
    logic                 w_push;
    logic [DATA_BITS-1:0] r_rx_shift;

    assign o_TxRDY     = i_TxEN & ~r_hold_full & ~w_mode_echo;
    assign o_TxEMT     = ~r_hold_full & (r_tx_state == S_IDLE);
    assign w_wr        = bus.i_Cs & ~bus.i_Rw & o_TxRDY & ~i_TxReset;
    assign w_echo_load = w_push & w_mode_echo & ~r_hold_full & ~i_TxReset;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_tx_state  <= S_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_tx_par    <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else begin
            r_tx_state  <= w_tx_state_next;
            r_tx_cnt    <= w_tx_cnt_next;
            r_tx_bit    <= w_tx_bit_next;
            r_tx_shift  <= w_tx_shift_next;
            r_tx_par    <= w_tx_par_next;
            r_hold_full <= w_hold_full_next;
            r_hold_data <= w_hold_data_next;
        end
    end

    always_comb begin
        w_tx_state_next  = r_tx_state;
        w_tx_cnt_next    = r_tx_cnt;
        w_tx_bit_next    = r_tx_bit;
        w_tx_shift_next  = r_tx_shift;
        w_tx_par_next    = r_tx_par;
        w_hold_full_next = r_hold_full;
        w_hold_data_next = r_hold_data;
        w_tx_load        = 1'b0;
        case (r_tx_state)
            S_IDLE: w_tx_load = r_hold_full & i_TxEN;
            S_START: begin
                if (r_tx_cnt == LAST_CLK) begin
                    w_tx_cnt_next   = '0;
                    w_tx_bit_next   = '0;
                    w_tx_state_next = S_DATA;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_tx_cnt == LAST_CLK) begin
                    w_tx_cnt_next   = '0;
                    w_tx_shift_next = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                    if (r_tx_bit == LAST_BIT)
                        w_tx_state_next = w_par_en ? S_PARITY : S_STOP;
                    else
                        w_tx_bit_next = r_tx_bit + BIT_W'(1);
                end else begin
                    w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (r_tx_cnt == LAST_CLK) begin
                    w_tx_cnt_next   = '0;
                    w_tx_state_next = S_STOP;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (r_tx_cnt == LAST_CLK) begin
                    // Chain straight into the next start bit when a character waits
                    w_tx_cnt_next   = '0;
                    w_tx_load       = r_hold_full & i_TxEN;
                    w_tx_state_next = S_IDLE;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
                end
            end
            default: w_tx_state_next = S_IDLE;
        endcase
        if (w_tx_load) begin
            w_tx_state_next  = S_START;
            w_tx_cnt_next    = '0;
            w_tx_shift_next  = r_hold_data;
            w_tx_par_next    = (^r_hold_data) ^ w_par_odd;
            w_hold_full_next = 1'b0;
        end
        if (w_wr || w_echo_load) begin
            w_hold_full_next = 1'b1;
            w_hold_data_next = w_wr ? bus.i_Data[DATA_BITS-1:0] : r_rx_shift;
        end
        if (i_TxReset) begin
            w_tx_state_next  = S_IDLE;
            w_tx_cnt_next    = '0;
            w_tx_bit_next    = '0;
            w_hold_full_next = 1'b0;
        end
    end

    always_comb begin
        case (r_tx_state)
            S_START:  w_tx_line = 1'b0;
            S_DATA:   w_tx_line = r_tx_shift[0];
            S_PARITY: w_tx_line = r_tx_par;
            default:  w_tx_line = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------ RX
    logic r_rx_meta, r_rx_sync, r_rx_prev, w_rx_in;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= w_rx_in;
        end
    end

    assign w_rx_in = w_mode_local ? w_tx_line : r_rx_sync;
    assign o_TX    = w_mode_remote ? r_rx_sync : (w_mode_local ? 1'b1 : w_tx_line);

    state_t               r_rx_state, w_rx_state_next;
    logic [CNT_W-1:0]     r_rx_cnt, w_rx_cnt_next;
    logic [BIT_W-1:0]     r_rx_bit, w_rx_bit_next;
    logic [DATA_BITS-1:0] w_rx_shift_next;
    logic                 r_rx_parbit, w_rx_parbit_next;
    logic                 r_rx_armed, w_rx_armed_next;
    logic                 w_rx_stop, w_push_pe, w_push_fe, w_push_rb;

    // Flags evaluated against the stop-bit sample; a break is not also a parity error
    assign w_push_fe = ~w_rx_in;
    assign w_push_rb = w_push_fe & (r_rx_shift == '0) & ~r_rx_parbit;
    assign w_push_pe = w_par_en & ((^{r_rx_shift, r_rx_parbit}) ^ w_par_odd) & ~w_push_rb;
    assign w_push    = w_rx_stop & ~w_mode_remote & ~i_RxReset;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_rx_state  <= S_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_parbit <= 1'b0;
            r_rx_armed  <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_state_next;
            r_rx_cnt    <= w_rx_cnt_next;
            r_rx_bit    <= w_rx_bit_next;
            r_rx_shift  <= w_rx_shift_next;
            r_rx_parbit <= w_rx_parbit_next;
            r_rx_armed  <= w_rx_armed_next;
        end
    end

    always_comb begin
        w_rx_state_next  = r_rx_state;
        w_rx_cnt_next    = r_rx_cnt;
        w_rx_bit_next    = r_rx_bit;
        w_rx_shift_next  = r_rx_shift;
        w_rx_parbit_next = r_rx_parbit;
        w_rx_armed_next  = r_rx_armed;
        w_rx_stop        = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                if (w_rx_in)
                    w_rx_armed_next = 1'b1;
                // The edge cycle is bit-cycle 0, so counting resumes at 1
                if (i_RxEN && r_rx_armed && r_rx_prev && !w_rx_in) begin
                    w_rx_state_next = S_START;
                    w_rx_cnt_next   = CNT_W'(1);
                end
            end
            S_START: begin
                if (r_rx_cnt == HALF_CLK) begin
                    w_rx_cnt_next    = '0;
                    w_rx_bit_next    = '0;
                    w_rx_parbit_next = 1'b0;
                    w_rx_state_next  = w_rx_in ? S_IDLE : S_DATA;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_rx_cnt == LAST_CLK) begin
                    w_rx_cnt_next   = '0;
                    w_rx_shift_next = {w_rx_in, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == LAST_BIT)
                        w_rx_state_next = w_par_en ? S_PARITY : S_STOP;
                    else
                        w_rx_bit_next = r_rx_bit + BIT_W'(1);
                end else begin
                    w_rx_cnt_next = r_rx_cnt + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (r_rx_cnt == LAST_CLK) begin
                    w_rx_cnt_next    = '0;
                    w_rx_parbit_next = w_rx_in;
                    w_rx_state_next  = S_STOP;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (r_rx_cnt == LAST_CLK) begin
                    w_rx_cnt_next   = '0;
                    w_rx_stop       = 1'b1;
                    w_rx_state_next = S_IDLE;
                    if (w_push_rb)
                        w_rx_armed_next = 1'b0;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + CNT_W'(1);
                end
            end
            default: w_rx_state_next = S_IDLE;
        endcase
        if (i_RxReset) begin
            w_rx_state_next = S_IDLE;
            w_rx_cnt_next   = '0;
            w_rx_armed_next = 1'b0;
        end
    end

    // ---------------------------------------------------------------- FIFO
    logic [EW-1:0]     r_fifo [RX_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [FCNT_W-1:0] r_fcount;
    logic              r_over;
    logic              w_empty, w_full, w_pop, w_fifo_wr;
    logic [EW-1:0]     w_head;

    assign w_empty   = (r_fcount == '0);
    assign w_full    = (r_fcount == DEPTH_C);
    assign w_pop     = bus.i_Cs & bus.i_Rw & ~w_empty & ~i_RxReset;
    assign w_fifo_wr = w_push & (~w_full | w_pop);

    always_ff @(posedge i_Clock) begin
        if (w_fifo_wr)
            r_fifo[r_wr_ptr] <= {w_push_rb, w_push_fe, w_push_pe, r_rx_shift};
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcount <= '0;
            r_over   <= 1'b0;
        end else begin
            if (i_RxReset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_fcount <= '0;
            end else begin
                if (w_fifo_wr)
                    r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
                if (w_fifo_wr && !w_pop)
                    r_fcount <= r_fcount + FCNT_W'(1);
                else if (!w_fifo_wr && w_pop)
                    r_fcount <= r_fcount - FCNT_W'(1);
            end
            if (i_ErrReset)
                r_over <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_over <= 1'b1;
        end
    end

    assign w_head     = r_fifo[r_rd_ptr];
    assign bus.o_Data = w_empty ? 8'h00 : 8'(w_head[DATA_BITS-1:0]);
    assign o_PE       = ~w_empty & w_head[DATA_BITS];
    assign o_FE       = ~w_empty & w_head[DATA_BITS+1];
    assign o_RB       = ~w_empty & w_head[DATA_BITS+2];
    assign o_RxRDY    = ~w_empty;
    assign o_FFULL    = w_full;
    assign o_OVER     = r_over;
endmodule
